// File: rtl/labfinal_soc_usb_ctrl_pio.sv
// Avalon-MM output PIO for USB controller control pins: static data word with
// set/clear access plus a hardware one-shot pulse overlay driven through a mask.
module labfinal_soc_usb_ctrl_pio #(
    parameter int          WIDTH       = 2,
    parameter int          CNT_W       = 16,
    parameter logic [31:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    typedef enum logic {IDLE, PULSE} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_nxt;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   r_mask;
    logic [31:0]        w_rd_mux;
    logic               w_wr;
    logic               w_busy;
    logic [WIDTH-1:0]   w_wd;
    logic [CNT_W-1:0]   w_len;
    logic               w_unused;

    assign w_wr     = chipselect & ~write_n;
    assign w_wd     = writedata[WIDTH-1:0];
    assign w_len    = writedata[CNT_W-1:0];
    assign w_unused = ^writedata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
        end
    end

    // A PLEN write always wins over the running countdown (retrigger/cancel).
    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        if (w_wr && address == 3'd3) begin
            if (w_len != '0) begin
                w_state_nxt = PULSE;
                w_count_nxt = w_len;
            end else begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end
        end else if (r_state == PULSE) begin
            if (r_count == CNT_W'(1)) begin
                w_state_nxt = IDLE;
                w_count_nxt = '0;
            end else begin
                w_count_nxt = r_count - CNT_W'(1);
            end
        end
    end

    always_comb begin
        w_busy = (r_state == PULSE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data <= RESET_VALUE[WIDTH-1:0];
            r_mask <= '0;
        end else if (w_wr) begin
            case (address)
                3'd0:    r_data <= w_wd;
                3'd2:    r_mask <= w_wd;
                3'd4:    r_data <= r_data | w_wd;
                3'd5:    r_data <= r_data & ~w_wd;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_rd_mux = '0;
        case (address)
            3'd0:    w_rd_mux[WIDTH-1:0] = r_data;
            3'd1:    w_rd_mux[0]         = w_busy;
            3'd2:    w_rd_mux[WIDTH-1:0] = r_mask;
            3'd3:    w_rd_mux[CNT_W-1:0] = r_count;
            default: w_rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) readdata <= '0;
        else       readdata <= w_rd_mux;
    end

    assign out_port = r_data | (w_busy ? r_mask : '0);

endmodule
